// File: rtl/motor_step_sequencer_pkg.sv
// Shared types and constants for the stepper-motor command sequencer.
package motor_pkg;

    localparam int unsigned N_MOTORS      = 4;
    localparam int unsigned MAX_BCD_DIGIT = 9;
    localparam int unsigned COUNT_W       = 10;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETUP,
        STEP_HI,
        STEP_LO,
        DONE,
        ERR
    } seq_state_t;

endpackage

// File: rtl/motor_step_sequencer_if.sv
// Parser command bus plus stepper-driver pins and status, grouped for the sequencer.
interface motor_step_sequencer_if;
    import motor_pkg::*;

    logic                i_motor_enable;
    logic [2:0]          i_motor;
    logic                i_direction;
    logic [3:0]          i_hundreds;
    logic [3:0]          i_tens;
    logic [3:0]          i_units;
    logic [N_MOTORS-1:0] o_step;
    logic [N_MOTORS-1:0] o_dir;
    logic [N_MOTORS-1:0] o_en;
    logic                o_busy;
    logic                o_done;
    logic                o_err;

    modport master (
        output i_motor_enable, i_motor, i_direction, i_hundreds, i_tens, i_units,
        input  o_step, o_dir, o_en, o_busy, o_done, o_err
    );

    modport slave (
        input  i_motor_enable, i_motor, i_direction, i_hundreds, i_tens, i_units,
        output o_step, o_dir, o_en, o_busy, o_done, o_err
    );

endinterface

// File: rtl/motor_step_sequencer_bcd.sv
// Combinational 3-digit BCD to binary converter using shift-add scaling.
module bcd3_to_bin
    import motor_pkg::*;
(
    input  logic [3:0]         hundreds_i,
    input  logic [3:0]         tens_i,
    input  logic [3:0]         units_i,
    output logic [COUNT_W-1:0] value_o,
    output logic               invalid_o
);

    logic [COUNT_W-1:0] h_w;
    logic [COUNT_W-1:0] t_w;
    logic [COUNT_W-1:0] u_w;

    always_comb begin
        h_w = COUNT_W'(hundreds_i);
        t_w = COUNT_W'(tens_i);
        u_w = COUNT_W'(units_i);
        // 100 = 64 + 32 + 4, 10 = 8 + 2
        value_o   = (h_w << 6) + (h_w << 5) + (h_w << 2)
                  + (t_w << 3) + (t_w << 1) + u_w;
        invalid_o = (hundreds_i > 4'(MAX_BCD_DIGIT))
                 || (tens_i     > 4'(MAX_BCD_DIGIT))
                 || (units_i    > 4'(MAX_BCD_DIGIT));
    end

endmodule

// File: rtl/motor_step_sequencer.sv
// Executes one parsed motor command: emits a BCD-specified number of STEP pulses
// on the selected driver with DIR/EN setup, and reports busy/done/error status.
module motor_step_sequencer
    import motor_pkg::*;
#(
    parameter int unsigned STEP_PERIOD = 100_000,
    parameter int unsigned HIGH_CYC    = 50_000,
    parameter int unsigned DIR_SETUP   = 1_000
) (
    input logic                   i_Clk,
    input logic                   i_Rst,
    motor_step_sequencer_if.slave bus
);

    localparam int unsigned    TMR_W    = $clog2(STEP_PERIOD + DIR_SETUP);
    localparam logic [TMR_W-1:0] SETUP_LD = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0] HI_LD    = TMR_W'(HIGH_CYC - 1);
    localparam logic [TMR_W-1:0] LO_LD    = TMR_W'(STEP_PERIOD - HIGH_CYC - 1);

    seq_state_t          state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [COUNT_W-1:0]  remain_q, remain_d;
    logic                enable_q;
    logic [2:0]          motor_q;
    logic                dir_q;
    logic [3:0]          hund_q, tens_q, units_q;

    logic [N_MOTORS-1:0] step_q, dir_out_q, en_out_q;
    logic                busy_q, done_q, err_q;

    logic                start;
    logic                tmr_zero;
    logic                drive_en;
    logic [N_MOTORS-1:0] sel_oh;
    logic [COUNT_W-1:0]  bcd_value;
    logic                bcd_invalid;

    bcd3_to_bin u_bcd (
        .hundreds_i (hund_q),
        .tens_i     (tens_q),
        .units_i    (units_q),
        .value_o    (bcd_value),
        .invalid_o  (bcd_invalid)
    );

    always_comb begin
        sel_oh = '0;
        for (int unsigned k = 0; k < N_MOTORS; k++) begin
            sel_oh[k] = (motor_q == 3'(k + 1));
        end
    end

    assign start    = bus.i_motor_enable && !enable_q && (state_q == IDLE);
    assign tmr_zero = (timer_q == '0);

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        remain_d = remain_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                if (bcd_invalid || !(|sel_oh)) begin
                    state_d = ERR;
                end else if (bcd_value == '0) begin
                    state_d = DONE;
                end else begin
                    state_d  = SETUP;
                    timer_d  = SETUP_LD;
                    remain_d = bcd_value;
                end
            end
            SETUP: begin
                if (tmr_zero) begin
                    state_d = STEP_HI;
                    timer_d = HI_LD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            STEP_HI: begin
                if (tmr_zero) begin
                    state_d  = STEP_LO;
                    timer_d  = LO_LD;
                    remain_d = remain_q - COUNT_W'(1);
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            STEP_LO: begin
                if (!tmr_zero) begin
                    timer_d = timer_q - TMR_W'(1);
                end else if (remain_q != '0) begin
                    state_d = STEP_HI;
                    timer_d = HI_LD;
                end else begin
                    state_d = DONE;
                end
            end
            DONE, ERR: state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // EN/DIR persist through DONE only when a stepping run preceded it (not for count 0)
    assign drive_en = (state_q inside {SETUP, STEP_HI, STEP_LO})
                   || ((state_q == DONE) && (|en_out_q));

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            remain_q <= '0;
            enable_q <= 1'b0;
            motor_q  <= '0;
            dir_q    <= 1'b0;
            hund_q   <= '0;
            tens_q   <= '0;
            units_q  <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            remain_q <= remain_d;
            enable_q <= bus.i_motor_enable;
            if (start) begin
                motor_q <= bus.i_motor;
                dir_q   <= bus.i_direction;
                hund_q  <= bus.i_hundreds;
                tens_q  <= bus.i_tens;
                units_q <= bus.i_units;
            end
        end
    end

    // Pin outputs are a registered decode of the current state, one cycle behind it
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            step_q    <= '0;
            dir_out_q <= '0;
            en_out_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            step_q    <= (state_q == STEP_HI) ? sel_oh : '0;
            en_out_q  <= drive_en ? sel_oh : '0;
            dir_out_q <= (drive_en && dir_q) ? sel_oh : '0;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_q == DONE);
            err_q     <= (state_q == ERR);
        end
    end

    assign bus.o_step = step_q;
    assign bus.o_dir  = dir_out_q;
    assign bus.o_en   = en_out_q;
    assign bus.o_busy = busy_q;
    assign bus.o_done = done_q;
    assign bus.o_err  = err_q;

endmodule

// File: tb/tb_motor_step_sequencer.sv
// Directed bench for motor_step_sequencer with a cycle-timeline reference model.
module tb_motor_step_sequencer;

    localparam int SP = 8;
    localparam int HC = 3;
    localparam int DS = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    motor_step_sequencer_if bus();

    motor_step_sequencer #(
        .STEP_PERIOD (SP),
        .HIGH_CYC    (HC),
        .DIR_SETUP   (DS)
    ) dut (
        .i_Clk (clk),
        .i_Rst (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference: the accepted command and the edge it started on
    int   t0 = 0;
    int   m_kind = 0;   // 0 none, 1 rejected, 2 zero count, 3 stepping run
    int   m_motor = 0;
    int   m_n = 0;
    int   m_last_busy = 0;
    logic m_dir = 1'b0;
    logic prev_en = 1'b0;

    // Independent observation counters
    int   pulses [4] = '{0, 0, 0, 0};
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   en_cycles = 0;
    int   last_done_cyc = 0;
    int   last_busy_cyc = 0;
    logic [3:0] prev_step = '0;
    int   start_cyc = 0;

    function automatic logic [14:0] expect_at(input int k);
        int t, end_t;
        logic [3:0] sel, step, dir, en;
        logic busy, done, err;
        step = '0; dir = '0; en = '0; busy = 1'b0; done = 1'b0; err = 1'b0;
        t = k - t0;
        if (m_kind == 1 || m_kind == 2) begin
            busy = (t >= 0 && t <= 1);
            err  = (m_kind == 1) && (t == 2);
            done = (m_kind == 2) && (t == 2);
        end else if (m_kind == 3) begin
            sel   = 4'(1 << (m_motor - 1));
            end_t = 2 + DS + m_n * SP;
            busy  = (t >= 0 && t < end_t);
            done  = (t == end_t);
            if (t >= 2 && t <= end_t) begin
                en  = sel;
                dir = m_dir ? sel : 4'b0000;
            end
            if (t >= 2 + DS && t < end_t && ((t - 2 - DS) % SP) < HC) step = sel;
        end
        return {step, dir, en, busy, done, err};
    endfunction

    always @(posedge clk) begin
        int h, tt, u;
        cyc = cyc + 1;
        if (!rst_n) begin
            m_kind  = 0;
            prev_en = 1'b0;
        end else begin
            if (bus.i_motor_enable && !prev_en &&
                (m_kind == 0 || cyc >= t0 + m_last_busy + 2)) begin
                h = int'(bus.i_hundreds); tt = int'(bus.i_tens); u = int'(bus.i_units);
                t0 = cyc;
                m_motor = int'(bus.i_motor);
                m_dir = bus.i_direction;
                if (h > 9 || tt > 9 || u > 9 || m_motor < 1 || m_motor > 4) begin
                    m_kind = 1; m_last_busy = 1;
                end else begin
                    m_n = h * 100 + tt * 10 + u;
                    if (m_n == 0) begin
                        m_kind = 2; m_last_busy = 1;
                    end else begin
                        m_kind = 3; m_last_busy = 1 + DS + m_n * SP;
                    end
                end
            end
            prev_en = bus.i_motor_enable;
        end
    end

    always @(negedge clk) begin
        logic [14:0] got, exp;
        if (rst_n) begin
            got = {bus.o_step, bus.o_dir, bus.o_en, bus.o_busy, bus.o_done, bus.o_err};
            exp = expect_at(cyc);
            checks = checks + 1;
            if (got !== exp) begin
                errors = errors + 1;
                $display("FAIL outputs cycle %0d: got step/dir/en/busy/done/err=%b expected %b",
                         cyc, got, exp);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_step = '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (bus.o_step[k] && !prev_step[k]) pulses[k] = pulses[k] + 1;
            end
            prev_step = bus.o_step;
            if (bus.o_done) begin done_cnt = done_cnt + 1; last_done_cyc = cyc; end
            if (bus.o_err) err_cnt = err_cnt + 1;
            if (|bus.o_en) en_cycles = en_cycles + 1;
            if (bus.o_busy) last_busy_cyc = cyc;
        end
    end

    task automatic check_int(input string name, input int got, input int exp);
        checks = checks + 1;
        if (got != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic start_cmd(input logic [2:0] m, input logic d, input logic [3:0] h,
                             input logic [3:0] t, input logic [3:0] u, input int hold);
        bus.i_motor = m;
        bus.i_direction = d;
        bus.i_hundreds = h;
        bus.i_tens = t;
        bus.i_units = u;
        bus.i_motor_enable = 1'b1;
        start_cyc = cyc + 1;
        repeat (hold) @(negedge clk);
        bus.i_motor_enable = 1'b0;
    endtask

    int b_p [4];
    int b_done, b_err, b_en;

    task automatic snap();
        for (int k = 0; k < 4; k++) b_p[k] = pulses[k];
        b_done = done_cnt;
        b_err  = err_cnt;
        b_en   = en_cycles;
    endtask

    task automatic reject_case(input string name, input logic [2:0] m, input logic [3:0] u);
        snap();
        start_cmd(m, 1'b1, 4'd0, 4'd0, u, 1);
        repeat (6) @(negedge clk);
        #1;
        check_int({name, " err pulses"}, err_cnt - b_err, 1);
        check_int({name, " busy last high offset"}, last_busy_cyc - start_cyc, 1);
        check_int({name, " en cycles"}, en_cycles - b_en, 0);
        check_int({name, " step pulses"},
                  pulses[0] + pulses[1] + pulses[2] + pulses[3]
                  - b_p[0] - b_p[1] - b_p[2] - b_p[3], 0);
    endtask

    initial begin
        int i;
        bus.i_motor_enable = 1'b0;
        bus.i_motor = '0;
        bus.i_direction = 1'b0;
        bus.i_hundreds = '0;
        bus.i_tens = '0;
        bus.i_units = '0;
        #1;
        check_int("reset outputs", int'({bus.o_step, bus.o_dir, bus.o_en,
                                         bus.o_busy, bus.o_done, bus.o_err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 12 pulses on motor 2, forward
        snap();
        start_cmd(3'd2, 1'b1, 4'd0, 4'd1, 4'd2, 1);
        repeat (110) @(negedge clk);
        #1;
        check_int("t1 pulses m2", pulses[1] - b_p[1], 12);
        check_int("t1 other pulses", pulses[0] + pulses[2] + pulses[3]
                                     - b_p[0] - b_p[2] - b_p[3], 0);
        check_int("t1 done count", done_cnt - b_done, 1);
        check_int("t1 done latency", last_done_cyc - start_cyc, 100);

        // zero count
        snap();
        start_cmd(3'd3, 1'b1, 4'd0, 4'd0, 4'd0, 1);
        repeat (6) @(negedge clk);
        #1;
        check_int("t2 done latency", last_done_cyc - start_cyc, 2);
        check_int("t2 done count", done_cnt - b_done, 1);
        check_int("t2 en cycles", en_cycles - b_en, 0);
        check_int("t2 pulses m3", pulses[2] - b_p[2], 0);

        // rejected commands
        reject_case("t3 motor0", 3'd0, 4'd1);
        reject_case("t3 motor5", 3'd5, 4'd1);
        reject_case("t3 digitA", 3'd2, 4'hA);

        // enable held high for 3 cycles
        snap();
        start_cmd(3'd1, 1'b0, 4'd0, 4'd0, 4'd3, 3);
        repeat (40) @(negedge clk);
        #1;
        check_int("t4 held pulses m1", pulses[0] - b_p[0], 3);
        check_int("t4 held done count", done_cnt - b_done, 1);

        // second edge while stepping
        snap();
        start_cmd(3'd2, 1'b1, 4'd0, 4'd0, 4'd4, 1);
        for (i = 0; i < 40 && !bus.o_step[1]; i++) begin
            @(negedge clk);
            #1;
        end
        check_int("t4 reached step high", int'(bus.o_step[1]), 1);
        start_cmd(3'd3, 1'b0, 4'd0, 4'd0, 4'd9, 1);
        repeat (50) @(negedge clk);
        #1;
        check_int("t4 retrig pulses m2", pulses[1] - b_p[1], 4);
        check_int("t4 retrig pulses m3", pulses[2] - b_p[2], 0);
        check_int("t4 retrig done count", done_cnt - b_done, 1);

        // reset during high phase of pulse 5
        snap();
        start_cmd(3'd1, 1'b1, 4'd0, 4'd1, 4'd0, 1);
        for (i = 0; i < 200 && !((pulses[0] - b_p[0] == 5) && bus.o_step[0]); i++) begin
            @(negedge clk);
            #1;
        end
        check_int("t5 reached pulse 5", pulses[0] - b_p[0], 5);
        #2;
        rst_n = 1'b0;
        #1;
        check_int("t5 outputs in reset", int'({bus.o_step, bus.o_dir, bus.o_en,
                                               bus.o_busy, bus.o_done, bus.o_err}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        #1;
        check_int("t5 pulses after reset", pulses[0] - b_p[0], 5);
        check_int("t5 done after reset", done_cnt - b_done, 0);

        // 299 pulses on motor 4, backward
        snap();
        start_cmd(3'd4, 1'b0, 4'd2, 4'd9, 4'd9, 1);
        repeat (2410) @(negedge clk);
        #1;
        check_int("t6 pulses m4", pulses[3] - b_p[3], 299);
        check_int("t6 done count", done_cnt - b_done, 1);
        check_int("t6 done latency", last_done_cyc - start_cyc, 2396);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
